hicore_wbck_arbiter: RTL and testbench

- Writeback arbiter directly upstream of the integer register file write port.
- Merges two writeback sources into the single regfile write port (wen/idx/dat):
  - the single-cycle ALU result path;
  - the long-pipe path (LSU loads, mul/div), buffered in a small FIFO.
- Gives long-pipe results priority, with a starvation guard for the ALU, and suppresses writes to x0.

---
 rtl/hicore_wbck_arbiter.sv | 153 +++++++++++++++
 tb/tb_hicore_wbck_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hicore_wbck_arbiter.sv
// hicore_wbck_arbiter
// Writeback arbiter in front of the integer register file write port.
// Merges the single-cycle ALU result path and the long-pipe path (loads,
// mul/div). Long-pipe results are buffered in a small FIFO and take
// priority. A starvation counter forces an ALU grant after STARVE_MAX
// consecutive stalled ALU cycles. Writes to x0 and faulting or non-writing
// ops complete their handshake without asserting the write enable.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   alu_wbck_*          ALU result handshake (valid/ready) plus en/idx/dat
//   longp_wbck_*        long-pipe result handshake plus err/idx/dat
//   wbck_dest_*         register file write port (wen/idx/dat)
//   longp_cnt           long-pipe FIFO occupancy
module hicore_wbck_arbiter #(
  parameter int REG_SIZE    = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int LONGP_DEPTH = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alu_wbck_valid,
  output logic                               alu_wbck_ready,
  input  logic                               alu_wbck_en,
  input  logic [RFIDX_WIDTH-1:0]             alu_wbck_idx,
  input  logic [REG_SIZE-1:0]                alu_wbck_dat,
  input  logic                               longp_wbck_valid,
  output logic                               longp_wbck_ready,
  input  logic                               longp_wbck_err,
  input  logic [RFIDX_WIDTH-1:0]             longp_wbck_idx,
  input  logic [REG_SIZE-1:0]                longp_wbck_dat,
  output logic                               wbck_dest_wen,
  output logic [RFIDX_WIDTH-1:0]             wbck_dest_idx,
  output logic [REG_SIZE-1:0]                wbck_dest_dat,
  output logic [$clog2(LONGP_DEPTH+1)-1:0]   longp_cnt
);

  localparam int CNT_W = $clog2(LONGP_DEPTH + 1);
  localparam int PTR_W = $clog2(LONGP_DEPTH);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(LONGP_DEPTH);
  localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);

  typedef struct packed {
    logic                   err;
    logic [RFIDX_WIDTH-1:0] idx;
    logic [REG_SIZE-1:0]    dat;
  } entry_t;

  entry_t           fifo_q [LONGP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic   longp_ready_s;
  logic   boost_s;
  logic   grant_longp_s;
  logic   grant_alu_s;
  logic   push_s;
  entry_t head_s;

  // Arbitration and handshakes; reset masks every grant and ready.
  always_comb begin
    head_s        = fifo_q[rd_ptr_q];
    longp_ready_s = ~rst & (cnt_q < DEPTH_C);
    boost_s       = alu_wbck_valid & (starve_q == STARVE_TOP);
    grant_longp_s = ~rst & (cnt_q != CNT_W'(0)) & ~boost_s;
    grant_alu_s   = ~rst & alu_wbck_valid & ~grant_longp_s;
    push_s        = longp_wbck_valid & longp_ready_s;
  end

  // Next-state for FIFO pointers, occupancy and the starvation counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (grant_longp_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, grant_longp_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    // Stalled ALU counts up (saturating); handshake or idle clears it.
    if (alu_wbck_valid & ~grant_alu_s) begin
      if (starve_q == STARVE_TOP) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + STV_W'(1);
      end
    end else begin
      starve_d = STV_W'(0);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      cnt_q    <= CNT_W'(0);
      starve_q <= STV_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= '{err: longp_wbck_err, idx: longp_wbck_idx, dat: longp_wbck_dat};
    end
  end

  // Write-port mux; x0 targets, en=0 and faulting ops consume without writing.
  always_comb begin
    wbck_dest_wen = 1'b0;
    wbck_dest_idx = RFIDX_WIDTH'(0);
    wbck_dest_dat = REG_SIZE'(0);
    if (grant_alu_s) begin
      wbck_dest_wen = alu_wbck_en & (alu_wbck_idx != RFIDX_WIDTH'(0));
      wbck_dest_idx = alu_wbck_idx;
      wbck_dest_dat = alu_wbck_dat;
    end else if (grant_longp_s) begin
      wbck_dest_wen = ~head_s.err & (head_s.idx != RFIDX_WIDTH'(0));
      wbck_dest_idx = head_s.idx;
      wbck_dest_dat = head_s.dat;
    end else begin
      wbck_dest_wen = 1'b0;
      wbck_dest_idx = RFIDX_WIDTH'(0);
      wbck_dest_dat = REG_SIZE'(0);
    end
  end

  assign alu_wbck_ready   = grant_alu_s;
  assign longp_wbck_ready = longp_ready_s;
  assign longp_cnt        = cnt_q;

endmodule

// File: tb/tb_hicore_wbck_arbiter.sv
// Self-checking bench for hicore_wbck_arbiter: directed scenarios followed
// by a randomized run checked against a queue-based reference model.
module tb_hicore_wbck_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wbck_valid;
  logic        alu_wbck_ready;
  logic        alu_wbck_en;
  logic [4:0]  alu_wbck_idx;
  logic [31:0] alu_wbck_dat;
  logic        longp_wbck_valid;
  logic        longp_wbck_ready;
  logic        longp_wbck_err;
  logic [4:0]  longp_wbck_idx;
  logic [31:0] longp_wbck_dat;
  logic        wbck_dest_wen;
  logic [4:0]  wbck_dest_idx;
  logic [31:0] wbck_dest_dat;
  logic [1:0]  longp_cnt;

  int total = 0;
  int bad   = 0;

  hicore_wbck_arbiter #(
    .REG_SIZE(32), .RFIDX_WIDTH(5), .LONGP_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
    .alu_wbck_en(alu_wbck_en), .alu_wbck_idx(alu_wbck_idx), .alu_wbck_dat(alu_wbck_dat),
    .longp_wbck_valid(longp_wbck_valid), .longp_wbck_ready(longp_wbck_ready),
    .longp_wbck_err(longp_wbck_err), .longp_wbck_idx(longp_wbck_idx),
    .longp_wbck_dat(longp_wbck_dat),
    .wbck_dest_wen(wbck_dest_wen), .wbck_dest_idx(wbck_dest_idx),
    .wbck_dest_dat(wbck_dest_dat), .longp_cnt(longp_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_wbck_valid   = 1'b0;
    alu_wbck_en      = 1'b0;
    alu_wbck_idx     = 5'd0;
    alu_wbck_dat     = 32'd0;
    longp_wbck_valid = 1'b0;
    longp_wbck_err   = 1'b0;
    longp_wbck_idx   = 5'd0;
    longp_wbck_dat   = 32'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    alu_wbck_valid = 1'b1; alu_wbck_en = 1'b1; alu_wbck_idx = 5'd5; alu_wbck_dat = 32'hCAFE0001;
    longp_wbck_valid = 1'b1; longp_wbck_idx = 5'd3; longp_wbck_dat = 32'h12345678;
    @(negedge clk);
    total++; if (alu_wbck_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%0b want=0", alu_wbck_ready); end
    total++; if (longp_wbck_ready !== 1'b0) begin bad++; $display("FAIL rst_longp_ready got=%0b want=0", longp_wbck_ready); end
    total++; if ({wbck_dest_wen, wbck_dest_idx, wbck_dest_dat} !== 38'd0) begin bad++;
      $display("FAIL rst_dest got wen=%0b idx=%0d dat=%h want all 0", wbck_dest_wen, wbck_dest_idx, wbck_dest_dat); end
    tick;
    rst = 1'b0;
    idle_inputs();
    alu_wbck_valid = 1'b1;
    @(negedge clk);
    total++; if (longp_wbck_ready !== 1'b1) begin bad++; $display("FAIL post_rst_longp_ready got=%0b want=1", longp_wbck_ready); end
    total++; if (alu_wbck_ready !== 1'b1) begin bad++; $display("FAIL post_rst_alu_ready got=%0b want=1", alu_wbck_ready); end
    total++; if (longp_cnt !== 2'd0) begin bad++; $display("FAIL post_rst_cnt got=%0d want=0", longp_cnt); end
    tick;
    idle_inputs();
    tick;
  endtask

  task automatic test_alu_only;
    alu_wbck_valid = 1'b1; alu_wbck_en = 1'b1; alu_wbck_idx = 5'd5; alu_wbck_dat = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (alu_wbck_ready !== 1'b1) begin bad++; $display("FAIL alu_only_ready got=%0b want=1", alu_wbck_ready); end
    total++; if ({wbck_dest_wen, wbck_dest_idx, wbck_dest_dat} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin bad++;
      $display("FAIL alu_only_dest got wen=%0b idx=%0d dat=%h want 1/5/deadbeef", wbck_dest_wen, wbck_dest_idx, wbck_dest_dat); end
    tick;
    idle_inputs();
    tick;
  endtask

  task automatic test_suppress;
    alu_wbck_valid = 1'b1; alu_wbck_en = 1'b1; alu_wbck_idx = 5'd0; alu_wbck_dat = 32'h0000AAAA;
    @(negedge clk);
    total++; if ({alu_wbck_ready, wbck_dest_wen} !== 2'b10) begin bad++;
      $display("FAIL x0_suppress got ready=%0b wen=%0b want ready=1 wen=0", alu_wbck_ready, wbck_dest_wen); end
    tick;
    alu_wbck_en = 1'b0; alu_wbck_idx = 5'd7;
    @(negedge clk);
    total++; if ({alu_wbck_ready, wbck_dest_wen} !== 2'b10) begin bad++;
      $display("FAIL en0_suppress got ready=%0b wen=%0b want ready=1 wen=0", alu_wbck_ready, wbck_dest_wen); end
    tick;
    idle_inputs();
    longp_wbck_valid = 1'b1; longp_wbck_err = 1'b1; longp_wbck_idx = 5'd3; longp_wbck_dat = 32'h0BAD0BAD;
    tick;
    idle_inputs();
    @(negedge clk);
    total++; if ({longp_cnt, wbck_dest_wen} !== {2'd1, 1'b0}) begin bad++;
      $display("FAIL err_pop got cnt=%0d wen=%0b want cnt=1 wen=0", longp_cnt, wbck_dest_wen); end
    tick;
    @(negedge clk);
    total++; if (longp_cnt !== 2'd0) begin bad++; $display("FAIL err_pop_drain got cnt=%0d want=0", longp_cnt); end
    tick;
  endtask

  task automatic test_priority;
    alu_wbck_valid = 1'b1; alu_wbck_en = 1'b1; alu_wbck_idx = 5'd4; alu_wbck_dat = 32'h22;
    longp_wbck_valid = 1'b1; longp_wbck_idx = 5'd9; longp_wbck_dat = 32'h11;
    @(negedge clk);
    total++; if ({alu_wbck_ready, wbck_dest_wen, wbck_dest_idx} !== {1'b1, 1'b1, 5'd4}) begin bad++;
      $display("FAIL prio_c0 got ready=%0b wen=%0b idx=%0d want 1/1/4", alu_wbck_ready, wbck_dest_wen, wbck_dest_idx); end
    tick;
    longp_wbck_valid = 1'b0;
    @(negedge clk);
    total++; if ({alu_wbck_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat} !== {1'b0, 1'b1, 5'd9, 32'h11}) begin bad++;
      $display("FAIL prio_c1 got ready=%0b wen=%0b idx=%0d dat=%h want 0/1/9/11", alu_wbck_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat); end
    tick;
    @(negedge clk);
    total++; if ({alu_wbck_ready, wbck_dest_idx, wbck_dest_dat} !== {1'b1, 5'd4, 32'h22}) begin bad++;
      $display("FAIL prio_c2 got ready=%0b idx=%0d dat=%h want 1/4/22", alu_wbck_ready, wbck_dest_idx, wbck_dest_dat); end
    tick;
    idle_inputs();
    tick;
  endtask

  // ALU always valid, long pipe always offering: four stalls, a boost that
  // lets the FIFO fill to two, then backpressure for one cycle.
  task automatic test_starve_full;
    int a, p;
    logic       e_ar, e_lr;
    logic [1:0] e_cnt;
    logic [4:0] e_idx;
    logic [31:0] e_dat;
    a = 0; p = 0;
    for (int c = 0; c < 8; c++) begin
      alu_wbck_valid = 1'b1; alu_wbck_en = 1'b1; alu_wbck_idx = 5'd20; alu_wbck_dat = 32'h200 + a;
      longp_wbck_valid = 1'b1; longp_wbck_err = 1'b0; longp_wbck_idx = 5'(10 + p); longp_wbck_dat = 32'h100 + p;
      e_ar  = (c == 0) || (c == 5);
      e_lr  = (c != 6);
      e_cnt = (c == 0) ? 2'd0 : (c == 6) ? 2'd2 : 2'd1;
      if (e_ar) e_idx = 5'd20;
      else if (c <= 4) e_idx = 5'(10 + c - 1);
      else e_idx = 5'(c + 8);
      e_dat = e_ar ? 32'h200 + a : 32'h100 + (e_idx - 10);
      @(negedge clk);
      total++; if ({alu_wbck_ready, longp_wbck_ready, longp_cnt} !== {e_ar, e_lr, e_cnt}) begin bad++;
        $display("FAIL starve_ctl c%0d got ar=%0b lr=%0b cnt=%0d want ar=%0b lr=%0b cnt=%0d",
                 c, alu_wbck_ready, longp_wbck_ready, longp_cnt, e_ar, e_lr, e_cnt); end
      total++; if ({wbck_dest_wen, wbck_dest_idx, wbck_dest_dat} !== {1'b1, e_idx, e_dat}) begin bad++;
        $display("FAIL starve_dest c%0d got wen=%0b idx=%0d dat=%h want 1/%0d/%h",
                 c, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, e_idx, e_dat); end
      if (e_ar) a++;
      if (e_lr) p++;
      tick;
    end
    idle_inputs();
    @(negedge clk);
    total++; if ({wbck_dest_wen, wbck_dest_idx, longp_cnt} !== {1'b1, 5'd16, 2'd1}) begin bad++;
      $display("FAIL starve_order got wen=%0b idx=%0d cnt=%0d want 1/16/1", wbck_dest_wen, wbck_dest_idx, longp_cnt); end
    tick;
    @(negedge clk);
    total++; if ({wbck_dest_wen, longp_cnt} !== {1'b0, 2'd0}) begin bad++;
      $display("FAIL starve_drain got wen=%0b cnt=%0d want 0/0", wbck_dest_wen, longp_cnt); end
    tick;
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 4; c++) begin
      alu_wbck_valid = 1'b1; alu_wbck_en = 1'b1; alu_wbck_idx = 5'd20; alu_wbck_dat = (c == 0) ? 32'h200 : 32'h201;
      longp_wbck_valid = 1'b1; longp_wbck_err = 1'b0; longp_wbck_idx = 5'(10 + c); longp_wbck_dat = 32'h100 + c;
      tick;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({alu_wbck_ready, longp_wbck_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat} !== 40'd0) begin bad++;
      $display("FAIL midrst_outputs got ar=%0b lr=%0b wen=%0b idx=%0d dat=%h want all 0",
               alu_wbck_ready, longp_wbck_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat); end
    tick;
    rst = 1'b0;
    longp_wbck_valid = 1'b0;
    alu_wbck_idx = 5'd21; alu_wbck_dat = 32'h300;
    @(negedge clk);
    total++; if ({longp_cnt, longp_wbck_ready} !== {2'd0, 1'b1}) begin bad++;
      $display("FAIL midrst_fifo got cnt=%0d lr=%0b want 0/1", longp_cnt, longp_wbck_ready); end
    total++; if ({alu_wbck_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat} !== {1'b1, 1'b1, 5'd21, 32'h300}) begin bad++;
      $display("FAIL midrst_stale got ar=%0b wen=%0b idx=%0d dat=%h want 1/1/21/300",
               alu_wbck_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat); end
    tick;
    longp_wbck_valid = 1'b1; longp_wbck_idx = 5'd12; longp_wbck_dat = 32'h55;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++; if (alu_wbck_ready !== ((k == 0) || (k == 5))) begin bad++;
        $display("FAIL midrst_starve k%0d got ar=%0b want %0b", k, alu_wbck_ready, (k == 0) || (k == 5)); end
      tick;
    end
    idle_inputs();
    tick; tick; tick;
  endtask

  task automatic test_random;
    logic [37:0] q[$];
    logic [37:0] hd;
    int   starve;
    logic alu_acc, lp_acc;
    logic e_lr, e_ar, e_wen, gl, boost;
    logic [4:0]  e_idx;
    logic [31:0] e_dat;
    logic [1:0]  e_cnt;
    starve = 0; alu_acc = 1'b1; lp_acc = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (!(alu_wbck_valid && !alu_acc)) begin
        alu_wbck_valid = ($urandom_range(0, 9) < 7);
        alu_wbck_en    = ($urandom_range(0, 3) != 0);
        alu_wbck_idx   = 5'($urandom_range(0, 7));
        alu_wbck_dat   = $urandom;
      end
      if (!(longp_wbck_valid && !lp_acc)) begin
        longp_wbck_valid = ($urandom_range(0, 9) < 6);
        longp_wbck_err   = ($urandom_range(0, 4) == 0);
        longp_wbck_idx   = 5'($urandom_range(0, 7));
        longp_wbck_dat   = $urandom;
      end
      rst = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      e_cnt = 2'(q.size());
      e_wen = 1'b0; e_idx = 5'd0; e_dat = 32'd0;
      if (rst) begin
        e_lr = 1'b0; e_ar = 1'b0; gl = 1'b0;
      end else begin
        e_lr  = (q.size() < DEPTH);
        boost = alu_wbck_valid && (starve == SMAX);
        gl    = (q.size() > 0) && !boost;
        e_ar  = alu_wbck_valid && !gl;
        if (e_ar) begin
          e_wen = alu_wbck_en && (alu_wbck_idx != 5'd0);
          e_idx = alu_wbck_idx; e_dat = alu_wbck_dat;
        end else if (gl) begin
          hd = q[0];
          e_wen = !hd[37] && (hd[36:32] != 5'd0);
          e_idx = hd[36:32]; e_dat = hd[31:0];
        end
      end
      total++; if ({alu_wbck_ready, longp_wbck_ready, longp_cnt} !== {e_ar, e_lr, e_cnt}) begin bad++;
        $display("FAIL rand_ctl n%0d got ar=%0b lr=%0b cnt=%0d want ar=%0b lr=%0b cnt=%0d",
                 n, alu_wbck_ready, longp_wbck_ready, longp_cnt, e_ar, e_lr, e_cnt); end
      total++; if ({wbck_dest_wen, wbck_dest_idx, wbck_dest_dat} !== {e_wen, e_idx, e_dat}) begin bad++;
        $display("FAIL rand_dest n%0d got wen=%0b idx=%0d dat=%h want wen=%0b idx=%0d dat=%h",
                 n, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, e_wen, e_idx, e_dat); end
      lp_acc  = longp_wbck_valid && e_lr;
      alu_acc = e_ar;
      if (rst) begin
        q.delete();
        starve = 0;
      end else begin
        if (gl) void'(q.pop_front());
        if (lp_acc) q.push_back({longp_wbck_err, longp_wbck_idx, longp_wbck_dat});
        if (alu_wbck_valid && !e_ar) starve = (starve < SMAX) ? starve + 1 : SMAX;
        else starve = 0;
      end
      tick;
    end
    rst = 1'b0;
    idle_inputs();
    tick;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick;
    test_reset();
    test_alu_only();
    test_suppress();
    test_priority();
    test_starve_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
